p2s_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one parallel2serial serializer among N byte requesters. It latches the winning requester's byte and drives the serializer's a/parallel_begin inputs. It then waits for serial_end and returns a per-requester acknowledge. A watchdog aborts a transfer if serial_end never arrives.

---
 rtl/p2s_arbiter.sv | 105 ++++++++++
 tb/tb_p2s_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter that shares one parallel-to-serial serializer among N
// byte requesters, with a watchdog that aborts a transfer lacking serial_end.
module p2s_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data,
  output logic [N-1:0]         ack,
  output logic                 err,
  output logic                 busy,
  output logic [$clog2(N)-1:0] cur_id,
  output logic [W-1:0]         p2s_a,
  output logic                 p2s_begin,
  input  logic                 p2s_serial_end
);
  localparam int IDW = $clog2(N);
  localparam int TW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [TW-1:0]  timer, timer_n;
  logic [IDW-1:0] cur_id_n, win;
  logic [W-1:0]   p2s_a_n;
  logic [N-1:0]   ack_n;
  logic           err_n, begin_n, busy_n;

  // First set request at or after ptr, wrapping mod N.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) win = IDW'(j);
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    timer_n  = timer;
    cur_id_n = cur_id;
    p2s_a_n  = p2s_a;
    ack_n    = '0;
    err_n    = 1'b0;
    begin_n  = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_n  = LOAD;
        cur_id_n = win;
        p2s_a_n  = data[win*W +: W];
        begin_n  = 1'b1;
      end
      LOAD: begin
        state_n = WAIT;
        timer_n = '0;
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        // serial_end wins over a simultaneous watchdog expiry
        if (p2s_serial_end || timer == TW'(TIMEOUT - 1)) begin
          state_n         = DONE;
          ack_n[cur_id]   = 1'b1;
          err_n           = ~p2s_serial_end;
        end
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = (cur_id == IDW'(N - 1)) ? '0 : cur_id + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      timer     <= '0;
      cur_id    <= '0;
      p2s_a     <= '0;
      p2s_begin <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      timer     <= timer_n;
      cur_id    <= cur_id_n;
      p2s_a     <= p2s_a_n;
      p2s_begin <= begin_n;
      ack       <= ack_n;
      err       <= err_n;
      busy      <= busy_n;
    end
  end
endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed bench for p2s_arbiter with a behavioural LSB-first serializer stub.
module tb_p2s_arbiter;
  localparam int N = 4, W = 8, TIMEOUT = 16;

  logic           clk = 1'b0, reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   ack;
  logic           err, busy, p2s_begin;
  logic [1:0]     cur_id;
  logic [W-1:0]   p2s_a;

  logic           stub_end = 1'b0, stub_en = 1'b1, spur = 1'b0;
  logic [W-1:0]   sh = '0, cap = '0;
  int             cnt = 0, begin_cnt = 0;
  int             tests = 0, fails = 0;

  p2s_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack), .err(err),
    .busy(busy), .cur_id(cur_id), .p2s_a(p2s_a), .p2s_begin(p2s_begin),
    .p2s_serial_end(stub_end | spur)
  );

  always #5 clk = ~clk;

  // Serializer model: load on begin, shift LSB first for W cycles, then end pulse.
  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0; stub_end <= 1'b0;
    end else if (p2s_begin) begin
      sh <= p2s_a; cnt <= W; cap <= '0; stub_end <= 1'b0;
    end else if (cnt != 0) begin
      cap[W-cnt] <= sh[0];
      sh         <= sh >> 1;
      cnt        <= cnt - 1;
      stub_end   <= (cnt == 1) && stub_en;
    end else stub_end <= 1'b0;
    if (p2s_begin) begin_cnt <= begin_cnt + 1;
  end

  task automatic rst_dut();
    reset = 1'b1; req = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_begin(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (p2s_begin) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output logic e, output int c);
    a = '0; e = 1'b0; c = 0;
    while (c < 60) begin
      @(negedge clk); c++;
      if (ack !== '0) begin a = ack; e = err; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if ({ack, err, busy, cur_id, p2s_a, p2s_begin} !== '0) begin
      fails++; $display("FAIL reset_vals: got %h want 0", {ack, err, busy, cur_id, p2s_a, p2s_begin});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] a; logic e; int c;
    spur = 1'b1; @(negedge clk); spur = 1'b0; @(negedge clk);
    tests++;
    if (busy !== 1'b0 || ack !== '0) begin
      fails++; $display("FAIL spurious_idle: busy %b ack %b want 0 0", busy, ack);
    end
    data[0 +: W] = 8'b11010011; req = 4'b0001;
    @(negedge clk);
    tests++;
    if (p2s_begin !== 1'b1 || p2s_a !== 8'hD3 || cur_id !== 2'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_grant: begin %b a %h id %0d busy %b want 1 d3 0 1", p2s_begin, p2s_a, cur_id, busy);
    end
    @(negedge clk);
    tests++;
    if (p2s_begin !== 1'b0) begin fails++; $display("FAIL single_begin_width: got %b want 0", p2s_begin); end
    wait_ack(a, e, c);
    // c counts from the LOAD sample: W more for WAIT incl. end sample, +1 for DONE
    c = c + 1;
    tests++;
    if (a !== 4'b0001 || e !== 1'b0 || c !== W + 2) begin
      fails++; $display("FAIL single_ack: ack %b err %b lat %0d want 0001 0 %0d", a, e, c, W + 2);
    end
    tests++;
    if (cap !== 8'hD3) begin fails++; $display("FAIL single_serial: got %b want 11010011", cap); end
    req = '0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || ack !== '0) begin fails++; $display("FAIL single_idle: busy %b ack %b want 0 0", busy, ack); end
  endtask

  task automatic test_simul();
    logic [N-1:0] a; logic e; int c, b0; logic ok;
    rst_dut();
    b0 = begin_cnt;
    data[0 +: W] = 8'h11; data[2*W +: W] = 8'h22; req = 4'b0101;
    wait_begin(ok);
    tests++;
    if (!ok || cur_id !== 2'd0 || p2s_a !== 8'h11) begin
      fails++; $display("FAIL simul_first: ok %b id %0d a %h want 1 0 11", ok, cur_id, p2s_a);
    end
    wait_ack(a, e, c);
    req[0] = 1'b0;
    tests++;
    if (a !== 4'b0001) begin fails++; $display("FAIL simul_ack0: got %b want 0001", a); end
    wait_begin(ok);
    tests++;
    if (!ok || cur_id !== 2'd2 || p2s_a !== 8'h22) begin
      fails++; $display("FAIL simul_second: ok %b id %0d a %h want 1 2 22", ok, cur_id, p2s_a);
    end
    wait_ack(a, e, c);
    req[2] = 1'b0;
    tests++;
    if (a !== 4'b0100 || begin_cnt - b0 !== 2) begin
      fails++; $display("FAIL simul_ack2: ack %b begins %0d want 0100 2", a, begin_cnt - b0);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] a; logic e; int c, exp; logic ok;
    rst_dut();
    for (int i = 0; i < N; i++) data[i*W +: W] = W'(8'h10 * i + i);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp = k % N;
      wait_begin(ok);
      tests++;
      if (!ok || cur_id !== 2'(exp) || p2s_a !== W'(8'h10 * exp + exp)) begin
        fails++; $display("FAIL rr_grant%0d: id %0d a %h want %0d", k, cur_id, p2s_a, exp);
      end
      wait_ack(a, e, c);
      tests++;
      if (a !== 4'(1 << exp)) begin fails++; $display("FAIL rr_ack%0d: got %b want %b", k, a, 4'(1 << exp)); end
      req[exp] = 1'b0;
      @(negedge clk);
      req[exp] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] a; logic e; int c; logic ok;
    rst_dut();
    stub_en = 1'b0;
    data[1*W +: W] = 8'hA5; req = 4'b0010;
    wait_begin(ok);
    wait_ack(a, e, c);
    tests++;
    if (a !== 4'b0010 || e !== 1'b1 || c !== TIMEOUT + 1) begin
      fails++; $display("FAIL timeout_ack: ack %b err %b cyc %0d want 0010 1 %0d", a, e, c, TIMEOUT + 1);
    end
    req = '0; stub_en = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL timeout_idle: busy %b err %b want 0 0", busy, err); end
    // pointer now at 2: requester 3 must beat requester 0
    req = 4'b1001;
    @(negedge clk);
    tests++;
    if (p2s_begin !== 1'b1 || cur_id !== 2'd3) begin
      fails++; $display("FAIL timeout_ptr: begin %b id %0d want 1 3", p2s_begin, cur_id);
    end
    req = '0;
    wait_ack(a, e, c);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] a; logic e; int c; logic ok, seen;
    rst_dut();
    data[2*W +: W] = 8'h77; req = 4'b0100;
    wait_begin(ok); wait_ack(a, e, c);
    req = '0;
    @(negedge clk);
    data[1*W +: W] = 8'h5A; req = 4'b0010;
    wait_begin(ok);
    tests++;
    if (!ok || cur_id !== 2'd1) begin fails++; $display("FAIL mid_grant: id %0d want 1", cur_id); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || p2s_begin !== 1'b0 || p2s_a !== '0 || cur_id !== '0 || ack !== '0) begin
      fails++; $display("FAIL mid_reset: busy %b begin %b a %h id %0d ack %b want all 0", busy, p2s_begin, p2s_a, cur_id, ack);
    end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (ack !== '0) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_ack: got ack want none"); end
    data[0 +: W] = 8'h0A; data[3*W +: W] = 8'h3B; req = 4'b1001;
    wait_begin(ok);
    tests++;
    if (!ok || cur_id !== 2'd0 || p2s_a !== 8'h0A) begin
      fails++; $display("FAIL mid_ptr0: id %0d a %h want 0 0a", cur_id, p2s_a);
    end
    wait_ack(a, e, c);
    req[0] = 1'b0;
    wait_begin(ok);
    wait_ack(a, e, c);
    req[3] = 1'b0;
    tests++;
    if (a !== 4'b1000 || e !== 1'b0) begin fails++; $display("FAIL mid_req3: ack %b err %b want 1000 0", a, e); end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] a; logic e; int c; logic seen;
    rst_dut();
    data[2*W +: W] = 8'h3C; req = 4'b0100;
    @(negedge clk);
    req = '0; data[2*W +: W] = 8'hFF;
    wait_ack(a, e, c);
    tests++;
    if (a !== 4'b0100 || e !== 1'b0 || p2s_a !== 8'h3C || cap !== 8'h3C) begin
      fails++; $display("FAIL withdraw_ack: ack %b err %b a %h cap %h want 0100 0 3c 3c", a, e, p2s_a, cap);
    end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (ack !== '0) seen = 1'b1; end
    tests++;
    if (seen !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL withdraw_once: extra ack %b busy %b want 0 0", seen, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simul();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
